// File: rtl/rsa_job_sequencer.sv
// rtl/rsa_job_sequencer.sv - two-requester job sequencer in front of one RSA control core
//
// Purpose: arbitrates two job requesters round-robin, loads the shared core's p/q/mode/message,
// pulses key inversion (skipped when the key matches the last successfully inverted key) and
// modular exponentiation, waits on the core finish levels with a bounded wait, and returns the
// result (or a timeout error) on a valid/ready response port.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid[1:0], req_ready[1:0]    job request handshake, bit i = requester i
//   req{0,1}_p/q/mode/msg             job fields per requester (held stable while valid)
//   rsp_valid, rsp_ready              response handshake
//   rsp_id, rsp_msg, rsp_err          requester id, core result (0 on error), timeout flag
//   core_p/q/encrypt_decrypt/msg_in   core job inputs, stable from grant through response
//   core_reset_inverter/mod_exp       one-cycle start pulses to the core
//   core_inverter/mod_exp_finish      core done levels
//   core_msg_out                      core result
module rsa_job_sequencer #(
    parameter int WIDTH   = 128,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req0_p,
    input  logic [WIDTH-1:0]   req1_p,
    input  logic [WIDTH-1:0]   req0_q,
    input  logic [WIDTH-1:0]   req1_q,
    input  logic               req0_mode,
    input  logic               req1_mode,
    input  logic [2*WIDTH-1:0] req0_msg,
    input  logic [2*WIDTH-1:0] req1_msg,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_msg,
    output logic               rsp_err,
    output logic [WIDTH-1:0]   core_p,
    output logic [WIDTH-1:0]   core_q,
    output logic               core_encrypt_decrypt,
    output logic [2*WIDTH-1:0] core_msg_in,
    output logic               core_reset_inverter,
    output logic               core_reset_mod_exp,
    input  logic               core_inverter_finish,
    input  logic               core_mod_exp_finish,
    input  logic [2*WIDTH-1:0] core_msg_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INV_PULSE,
        S_INV_WAIT,
        S_EXP_PULSE,
        S_EXP_WAIT,
        S_RESP
    } state_t;

    // The wait counter counts completed wait cycles; the last permitted wait cycle is
    // TIMEOUT-1, so a hung core spends exactly TIMEOUT cycles in a wait state.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t           state, state_next;
    logic             rr;
    logic             grant;
    logic             any_req;
    logic             key_valid;
    logic [WIDTH-1:0] last_p, last_q;
    logic [15:0]      wait_cnt;
    logic             key_hit;
    logic             wait_first;
    logic             inv_done, exp_done, timed_out;

    assign any_req = |req_valid;
    // Pointer's requester first, otherwise the other one.
    assign grant   = req_valid[rr] ? rr : ~rr;
    assign key_hit = key_valid && (core_p == last_p) && (core_q == last_q);

    // The first wait cycle is blanked: the finish level may still be high from the previous
    // operation when the core has not yet reacted to the new start pulse.
    assign wait_first = (wait_cnt == 16'd0);
    assign inv_done   = (state == S_INV_WAIT) && !wait_first && core_inverter_finish;
    assign exp_done   = (state == S_EXP_WAIT) && !wait_first && core_mod_exp_finish;
    assign timed_out  = ((state == S_INV_WAIT) || (state == S_EXP_WAIT)) &&
                        !inv_done && !exp_done && (wait_cnt == LAST_WAIT);

    assign rsp_valid           = (state == S_RESP);
    assign core_reset_inverter = (state == S_INV_PULSE);
    assign core_reset_mod_exp  = (state == S_EXP_PULSE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (any_req) state_next = S_LOAD;
            S_LOAD:      state_next = key_hit ? S_EXP_PULSE : S_INV_PULSE;
            S_INV_PULSE: state_next = S_INV_WAIT;
            S_INV_WAIT: begin
                if (inv_done)       state_next = S_EXP_PULSE;
                else if (timed_out) state_next = S_RESP;
            end
            S_EXP_PULSE: state_next = S_EXP_WAIT;
            S_EXP_WAIT:  if (exp_done || timed_out) state_next = S_RESP;
            S_RESP:      if (rsp_ready) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready            <= '0;
            rr                   <= 1'b0;
            rsp_id               <= 1'b0;
            rsp_msg              <= '0;
            rsp_err              <= 1'b0;
            core_p               <= '0;
            core_q               <= '0;
            core_encrypt_decrypt <= 1'b0;
            core_msg_in          <= '0;
            key_valid            <= 1'b0;
            last_p               <= '0;
            last_q               <= '0;
            wait_cnt             <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        req_ready            <= grant ? 2'b10 : 2'b01;
                        rr                   <= ~grant;
                        rsp_id               <= grant;
                        core_p               <= grant ? req1_p    : req0_p;
                        core_q               <= grant ? req1_q    : req0_q;
                        core_encrypt_decrypt <= grant ? req1_mode : req0_mode;
                        core_msg_in          <= grant ? req1_msg  : req0_msg;
                    end
                end
                S_INV_PULSE, S_EXP_PULSE: begin
                    wait_cnt <= '0;
                end
                S_INV_WAIT: begin
                    if (inv_done) begin
                        last_p    <= core_p;
                        last_q    <= core_q;
                        key_valid <= 1'b1;
                    end else if (timed_out) begin
                        rsp_err   <= 1'b1;
                        rsp_msg   <= '0;
                        key_valid <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_EXP_WAIT: begin
                    if (exp_done) begin
                        rsp_msg <= core_msg_out;
                        rsp_err <= 1'b0;
                    end else if (timed_out) begin
                        rsp_err   <= 1'b1;
                        rsp_msg   <= '0;
                        key_valid <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb/tb_rsa_job_sequencer.sv - scoreboard bench for rsa_job_sequencer with a behavioural core
module tb_rsa_job_sequencer;

    localparam int W  = 128;
    localparam int TO = 64;

    logic           clk;
    logic           reset_n;
    logic           v0, v1;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   req0_p, req1_p, req0_q, req1_q;
    logic           req0_mode, req1_mode;
    logic [2*W-1:0] req0_msg, req1_msg;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [2*W-1:0] rsp_msg;
    logic [W-1:0]   core_p, core_q;
    logic           core_encrypt_decrypt;
    logic [2*W-1:0] core_msg_in;
    logic           core_reset_inverter, core_reset_mod_exp;
    logic           core_inverter_finish, core_mod_exp_finish;
    logic [2*W-1:0] core_msg_out;

    assign req_valid = {v1, v0};

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_p(req0_p), .req1_p(req1_p), .req0_q(req0_q), .req1_q(req1_q),
        .req0_mode(req0_mode), .req1_mode(req1_mode),
        .req0_msg(req0_msg), .req1_msg(req1_msg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_msg(rsp_msg), .rsp_err(rsp_err),
        .core_p(core_p), .core_q(core_q),
        .core_encrypt_decrypt(core_encrypt_decrypt), .core_msg_in(core_msg_in),
        .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
        .core_inverter_finish(core_inverter_finish), .core_mod_exp_finish(core_mod_exp_finish),
        .core_msg_out(core_msg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=wait bound expired required=event", name);
    endtask

    // Abstract core cipher: encryption adds the key {p,q}, decryption subtracts it, so a
    // decrypt of an encrypt under the same key returns the original message.
    function automatic logic [2*W-1:0] cipher(input logic [W-1:0] p, input logic [W-1:0] q,
                                              input logic m, input logic [2*W-1:0] msg);
        logic [2*W-1:0] k;
        k = {p, q};
        return m ? (msg - k) : (msg + k);
    endfunction

    function automatic logic [2*W-1:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- behavioural core ----------------
    logic           hang_inv = 1'b0, hang_exp = 1'b0;
    int             inv_cnt = 0, exp_cnt = 0;
    logic           inv_drop = 1'b0, exp_drop = 1'b0;
    logic [W-1:0]   ip = '0, iq = '0;
    logic           e_mode = 1'b0;
    logic [2*W-1:0] e_msg = '0;

    initial begin
        core_inverter_finish = 1'b0;
        core_mod_exp_finish  = 1'b0;
        core_msg_out         = '0;
    end

    // Finish levels stay high after completion and only drop one cycle after a new start,
    // so the sequencer's blanking cycle is exercised on every job after the first.
    always @(posedge clk) begin
        if (core_reset_inverter) begin
            ip       <= core_p;
            iq       <= core_q;
            inv_cnt  <= hang_inv ? 0 : int'($urandom_range(2, 12));
            inv_drop <= 1'b1;
        end else begin
            if (inv_drop) begin
                core_inverter_finish <= 1'b0;
                inv_drop             <= 1'b0;
            end
            if (inv_cnt != 0) begin
                inv_cnt <= inv_cnt - 1;
                if (inv_cnt == 1) core_inverter_finish <= 1'b1;
            end
        end
        if (core_reset_mod_exp) begin
            e_mode       <= core_encrypt_decrypt;
            e_msg        <= core_msg_in;
            exp_cnt      <= hang_exp ? 0 : int'($urandom_range(2, 12));
            exp_drop     <= 1'b1;
            core_msg_out <= rnd256();
        end else begin
            if (exp_drop) begin
                core_mod_exp_finish <= 1'b0;
                exp_drop            <= 1'b0;
            end
            if (exp_cnt != 0) begin
                exp_cnt <= exp_cnt - 1;
                if (exp_cnt == 1) begin
                    core_mod_exp_finish <= 1'b1;
                    core_msg_out        <= cipher(ip, iq, e_mode, e_msg);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic           id;
        logic [2*W-1:0] msg;
        logic           err;
        int             inv;
        int             exp;
        logic [W-1:0]   p;
        logic [W-1:0]   q;
        logic           mode;
        logic [2*W-1:0] min;
    } exp_t;

    exp_t           sb[$];
    logic           last_g = 1'b1;
    logic           kv = 1'b0;
    logic [W-1:0]   lp = '0, lq = '0;
    int             n_inv = 0, n_exp = 0, since = 0;
    logic           prev_valid = 1'b0, prev_hold = 1'b0, prev_id = 1'b0, prev_err = 1'b0;
    logic [2*W-1:0] prev_msg = '0;

    task automatic chk_core(input string name);
        if (sb.size() == 0) begin
            bound_expired({name, "_without_job"});
        end else begin
            check({name, "_core_p"},    core_p, sb[0].p);
            check({name, "_core_q"},    core_q, sb[0].q);
            check({name, "_core_mode"}, 256'(core_encrypt_decrypt), 256'(sb[0].mode));
            check({name, "_core_msg"},  core_msg_in, sb[0].min);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            last_g = 1'b1;
            kv = 1'b0;
            n_inv = 0; n_exp = 0; since = 0;
            prev_valid = 1'b0; prev_hold = 1'b0;
        end else begin
            since++;
            if (core_reset_inverter) begin n_inv++; since = 0; chk_core("inv_pulse"); end
            if (core_reset_mod_exp)  begin n_exp++; since = 0; chk_core("exp_pulse"); end

            if (|(req_valid & req_ready)) begin
                exp_t e;
                logic w;
                w = (req_valid == 2'b11) ? ~last_g : req_valid[1];
                check("grant", 256'(req_ready), w ? 256'd2 : 256'd1);
                last_g = w;
                e.id   = w;
                e.p    = w ? req1_p : req0_p;
                e.q    = w ? req1_q : req0_q;
                e.mode = w ? req1_mode : req0_mode;
                e.min  = w ? req1_msg : req0_msg;
                e.inv  = (kv && e.p == lp && e.q == lq) ? 0 : 1;
                e.exp  = 0;
                e.err  = 1'b0;
                e.msg  = '0;
                if (e.inv == 1 && hang_inv) begin
                    e.err = 1'b1;
                    kv = 1'b0;
                end else begin
                    if (e.inv == 1) begin kv = 1'b1; lp = e.p; lq = e.q; end
                    e.exp = 1;
                    if (hang_exp) begin
                        e.err = 1'b1;
                        kv = 1'b0;
                    end else begin
                        e.msg = cipher(e.p, e.q, e.mode, e.min);
                    end
                end
                sb.push_back(e);
            end

            if (rsp_valid) begin
                check("no_grant_in_resp", 256'(req_ready), 256'd0);
                if (prev_hold) begin
                    check("hold_id",  256'(rsp_id), 256'(prev_id));
                    check("hold_msg", rsp_msg, prev_msg);
                    check("hold_err", 256'(rsp_err), 256'(prev_err));
                end
                if (!prev_valid && sb.size() > 0 && sb[0].err)
                    check("timeout_cycles", 256'(since), 256'(TO + 1));
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        bound_expired("unexpected_rsp");
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_id",     256'(rsp_id), 256'(e.id));
                        check("rsp_msg",    rsp_msg, e.msg);
                        check("rsp_err",    256'(rsp_err), 256'(e.err));
                        check("inv_pulses", 256'(n_inv), 256'(e.inv));
                        check("exp_pulses", 256'(n_exp), 256'(e.exp));
                    end
                    n_inv = 0;
                    n_exp = 0;
                end
            end
            prev_valid = rsp_valid;
            prev_hold  = rsp_valid && !rsp_ready;
            prev_id    = rsp_id;
            prev_msg   = rsp_msg;
            prev_err   = rsp_err;
        end
    end

    // ---------------- stimulus ----------------
    logic hold_rsp = 1'b0;

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int id, input logic [W-1:0] p, input logic [W-1:0] q,
                        input logic m, input logic [2*W-1:0] msg);
        int n;
        @(posedge clk);
        #1;
        if (id == 0) begin
            req0_p = p; req0_q = q; req0_mode = m; req0_msg = msg; v0 = 1'b1;
        end else begin
            req1_p = p; req1_q = q; req1_mode = m; req1_msg = msg; v1 = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 2000);
        if (n >= 2000) bound_expired("req_accept");
        @(posedge clk);
        #1;
        if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || v0 || v1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) bound_expired("drain");
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_req_ready", 256'(req_ready), 256'd0);
        check("rst_rsp_valid", 256'(rsp_valid), 256'd0);
        check("rst_rsp",       {rsp_msg[2*W-3:0], rsp_id, rsp_err}, '0);
        check("rst_core_pq",   {core_p, core_q}, '0);
        check("rst_core_msg",  core_msg_in, '0);
        check("rst_core_ctl",  256'({core_encrypt_decrypt, core_reset_inverter, core_reset_mod_exp}),
              256'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    localparam logic [W-1:0]   P1 = 128'd113680897410347;
    localparam logic [W-1:0]   Q1 = 128'd7999808077935876437321;
    localparam logic [2*W-1:0] M1 = 256'hf03a_00000000000000;

    logic [W-1:0]   kp[3];
    logic [W-1:0]   kq[3];
    logic [2*W-1:0] snap;

    initial begin
        kp[0] = P1;                       kq[0] = Q1;
        kp[1] = 128'd8475698667747010771; kq[1] = 128'd11297384090418420749;
        kp[2] = 128'd8786194473250302299; kq[2] = 128'd1974551434103086991;
        v0 = 1'b0; v1 = 1'b0;
        req0_p = '0; req0_q = '0; req0_mode = 1'b0; req0_msg = '0;
        req1_p = '0; req1_q = '0; req1_mode = 1'b0; req1_msg = '0;
        reset_n = 1'b1;
        do_reset();

        // encrypt then decrypt round trip, second job hits the key cache
        send(0, P1, Q1, 1'b0, M1);
        drain();
        send(0, P1, Q1, 1'b1, cipher(P1, Q1, 1'b0, M1));
        drain();

        // simultaneous requests after reset, then a second simultaneous pair
        do_reset();
        fork
            send(0, kp[1], kq[1], 1'b0, rnd256());
            send(1, kp[2], kq[2], 1'b0, rnd256());
        join
        drain();
        fork
            send(0, kp[1], kq[1], 1'b1, rnd256());
            send(1, kp[2], kq[2], 1'b1, rnd256());
        join
        drain();

        // timeouts: inversion hang, then cached key with exponentiation hang, then re-invert
        hang_inv = 1'b1;
        send(0, P1, Q1, 1'b0, rnd256());
        drain();
        hang_inv = 1'b0;
        send(1, P1, Q1, 1'b0, rnd256());
        drain();
        hang_exp = 1'b1;
        send(0, P1, Q1, 1'b0, rnd256());
        drain();
        hang_exp = 1'b0;
        send(0, P1, Q1, 1'b0, rnd256());
        drain();

        // back-pressure: response held 10 cycles while the other requester waits
        hold_rsp = 1'b1;
        send(0, kp[1], kq[1], 1'b0, rnd256());
        fork
            send(1, kp[2], kq[2], 1'b0, rnd256());
        join_none
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
            if (n >= 2000) bound_expired("hold_rsp_valid");
        end
        snap = rsp_msg;
        repeat (10) begin
            @(negedge clk);
            check("held_valid", 256'(rsp_valid), 256'd1);
            check("held_msg", rsp_msg, snap);
        end
        hold_rsp = 1'b0;
        drain();

        // reset during exponentiation wait of a cached-key job; the key must be re-inverted
        send(0, P1, Q1, 1'b0, rnd256());
        drain();
        hang_exp = 1'b1;
        send(0, P1, Q1, 1'b0, rnd256());
        begin
            int n;
            n = 0;
            while (!core_reset_mod_exp && n < 2000) begin @(negedge clk); n++; end
            if (n >= 2000) bound_expired("exp_pulse_before_reset");
        end
        repeat (3) @(negedge clk);
        hang_exp = 1'b0;
        do_reset();
        send(0, P1, Q1, 1'b0, rnd256());
        drain();

        // randomized traffic over a small key pool so cache hits and misses both occur
        for (int i = 0; i < 24; i++) begin
            int a, b;
            a = $urandom_range(0, 2);
            b = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) begin
                fork
                    send(0, kp[a], kq[a], 1'($urandom_range(0, 1)), rnd256());
                    send(1, kp[b], kq[b], 1'($urandom_range(0, 1)), rnd256());
                join
            end else begin
                send($urandom_range(0, 1), kp[a], kq[a], 1'($urandom_range(0, 1)), rnd256());
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
